// File: rtl/cpu_pkg.sv
// Shared CPU types for the branch unit: condition codes, FSM states,
// the captured branch record and the PC-relative target helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        NE = 3'b000,
        EQ = 3'b001,
        GT = 3'b010,
        LT = 3'b011,
        GE = 3'b100,
        LE = 3'b101,
        OV = 3'b110,
        UN = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2
    } br_state_e;

    typedef struct packed {
        logic [2:0]  cond;
        logic        is_reg;
        logic [15:0] pc_plus2;
        logic [8:0]  imm9;
        logic [15:0] rs_data;
    } br_fields_t;

    localparam logic [1:0] PEND_MAX = 2'd3;

    // Word offset: sign-extend imm9 and scale by 2; overflow simply wraps.
    function automatic logic [15:0] rel_target(input logic [15:0] pc, input logic [8:0] imm);
        return pc + {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational condition-code decoder: met=1 when cond holds for N/Z/V.
module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       Z,
    input  logic       V,
    output logic       met
);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        met = 1'b0;
        unique case (cond_e'(cond))
            NE: met = !Z;
            EQ: met = Z;
            GT: met = !Z && !N;
            LT: met = N;
            GE: met = Z || (!Z && !N);
            LE: met = N || Z;
            OV: met = V;
            UN: met = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: holds fetch until in-flight flag writers drain, then
// evaluates the condition. Optional BRANCH_STATS_EN adds taken/total counters.
module branch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic        br_reg,
    input  logic [15:0] pc_plus2,
    input  logic [8:0]  imm9,
    input  logic [15:0] rs_data,
    input  logic        flag_set,
    input  logic        flag_done,
    input  logic        N_flag,
    input  logic        Z_flag,
    input  logic        V_flag,
    output logic        stall,
    output logic        resolved,
    output logic        taken,
    output logic [15:0] target
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_total_cnt
`endif
);

    br_state_e  state, state_nxt;
    logic [1:0] pend_cnt, pend_nxt;
    br_fields_t cap;
    logic       capture;
    logic       cond_met;

    br_cond_eval u_cond_eval (
        .cond (cap.cond),
        .N    (N_flag),
        .Z    (Z_flag),
        .V    (V_flag),
        .met  (cond_met)
    );

    always_comb begin
        pend_nxt = pend_cnt;
        if (flag_set && !flag_done && pend_cnt != PEND_MAX)
            pend_nxt = pend_cnt + 2'd1;
        else if (flag_done && !flag_set && pend_cnt != 2'd0)
            pend_nxt = pend_cnt - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (br_valid) begin
                    stall     = 1'b1;
                    capture   = 1'b1;
                    state_nxt = (pend_cnt == 2'd0 && !flag_set && !flag_done) ? EVAL : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // Leave as the last write lands so EVAL sees the freshly written flags.
                if (pend_nxt == 2'd0)
                    state_nxt = EVAL;
            end
            EVAL: begin
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the captured record is
    // a plain register (not a memory), so it is cleared by reset like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_cnt <= 2'd0;
            cap      <= '0;
            resolved <= 1'b0;
            taken    <= 1'b0;
            target   <= 16'h0000;
        end else begin
            state    <= state_nxt;
            pend_cnt <= pend_nxt;
            resolved <= (state == EVAL);
            if (capture)
                cap <= '{cond: br_cond, is_reg: br_reg, pc_plus2: pc_plus2,
                         imm9: imm9, rs_data: rs_data};
            if (state == EVAL) begin
                taken <= cond_met;
                if (!cond_met)
                    target <= cap.pc_plus2;
                else if (cap.is_reg)
                    target <= cap.rs_data;
                else
                    target <= rel_target(cap.pc_plus2, cap.imm9);
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt <= 16'h0000;
            br_total_cnt <= 16'h0000;
        end else if (resolved) begin
            if (br_total_cnt != 16'hFFFF)
                br_total_cnt <= br_total_cnt + 16'd1;
            if (taken && br_taken_cnt != 16'hFFFF)
                br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed corner cases plus random traffic
// against a reference model. Define BRANCH_STATS_EN to also check the counters.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        br_reg;
    logic [15:0] pc_plus2;
    logic [8:0]  imm9;
    logic [15:0] rs_data;
    logic        flag_set;
    logic        flag_done;
    logic        N_flag, Z_flag, V_flag;
    logic        stall, resolved, taken;
    logic [15:0] target;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_taken_cnt, br_total_cnt;
`endif

    branch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_reg    (br_reg),
        .pc_plus2  (pc_plus2),
        .imm9      (imm9),
        .rs_data   (rs_data),
        .flag_set  (flag_set),
        .flag_done (flag_done),
        .N_flag    (N_flag),
        .Z_flag    (Z_flag),
        .V_flag    (V_flag),
        .stall     (stall),
        .resolved  (resolved),
        .taken     (taken),
        .target    (target)
`ifdef BRANCH_STATS_EN
        ,
        .br_taken_cnt (br_taken_cnt),
        .br_total_cnt (br_total_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          taken;
        logic [15:0] target;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          cnt_m    = 0;
    bit          busy_m   = 0;
    bit          eval_m   = 0;
    int          issue_c  = 0;
    logic [2:0]  m_cond;
    bit          m_reg;
    logic [15:0] m_pc, m_rs;
    logic [8:0]  m_imm;
    int          tot_m    = 0;
    int          tak_m    = 0;

    function automatic bit cond_holds(input logic [2:0] c, input bit n, input bit z, input bit v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   off;
        if (!rst_n) begin
            busy_m = 0;
            eval_m = 0;
            cnt_m  = 0;
            tot_m  = 0;
            tak_m  = 0;
            exp_q.delete();
        end else begin
            if (busy_m && eval_m) begin
                e.taken = cond_holds(m_cond, N_flag, Z_flag, V_flag);
                off     = int'($signed(m_imm));
                if (!e.taken)   e.target = m_pc;
                else if (m_reg) e.target = m_rs;
                else            e.target = 16'(int'(m_pc) + 2 * off);
                e.due = cyc + 1;
                exp_q.push_back(e);
                tot_m++;
                if (e.taken) tak_m++;
                busy_m = 0;
                eval_m = 0;
            end else if (!busy_m && br_valid) begin
                m_cond  = br_cond;
                m_reg   = br_reg;
                m_pc    = pc_plus2;
                m_imm   = imm9;
                m_rs    = rs_data;
                busy_m  = 1;
                issue_c = cyc;
                eval_m  = (cnt_m == 0 && !flag_set && !flag_done);
            end
            if (flag_set && !flag_done && cnt_m < 3)      cnt_m++;
            else if (flag_done && !flag_set && cnt_m > 0) cnt_m--;
            // A delayed branch evaluates in the first cycle (two or more after issue) with no writes pending.
            if (busy_m && cyc + 1 >= issue_c + 2)
                eval_m = (cnt_m == 0);
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_stall", 32'(stall), 0);
            check("rst_resolved", 32'(resolved), 0);
            check("rst_taken", 32'(taken), 0);
            check("rst_target", 32'(target), 0);
`ifdef BRANCH_STATS_EN
            check("rst_total_cnt", 32'(br_total_cnt), 0);
            check("rst_taken_cnt", 32'(br_taken_cnt), 0);
`endif
        end else begin
            check("stall", 32'(stall), 32'(busy_m || br_valid));
            if (resolved) begin
                if (exp_q.size() == 0) begin
                    check("resolved_unexpected", 32'(resolved), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resolve_cycle", cyc, e.due);
                    check("taken", 32'(taken), 32'(e.taken));
                    check("target", 32'(target), 32'(e.target));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("resolved_missing", 32'(resolved), 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_branch(input logic [2:0] c, input logic r, input logic [15:0] pc,
                              input logic [8:0] imm, input logic [15:0] rs);
        br_cond  = c;
        br_reg   = r;
        pc_plus2 = pc;
        imm9     = imm;
        rs_data  = rs;
    endtask

    // Issue a branch with no pending flags and check it resolves two cycles later.
    task automatic quick_branch(input string tag, input logic [2:0] c, input logic r,
                                input logic [15:0] pc, input logic [8:0] imm,
                                input logic [15:0] rs, input logic exp_taken,
                                input logic [15:0] exp_target);
        set_branch(c, r, pc, imm, rs);
        br_valid = 1'b1;
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 32'(resolved), 0);
        next_cycle();
        @(negedge clk);
        check({tag, "_resolved"}, 32'(resolved), 1);
        check({tag, "_taken"}, 32'(taken), 32'(exp_taken));
        check({tag, "_target"}, 32'(target), 32'(exp_target));
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b1;
        br_valid = 1'b0; flag_set = 1'b0; flag_done = 1'b0;
        N_flag = 1'b0; Z_flag = 1'b0; V_flag = 1'b0;
        set_branch(3'd0, 1'b0, 16'h0, 9'h0, 16'h0);
        #3 rst_n = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        Z_flag = 1'b1;
        quick_branch("b_eq", 3'b001, 1'b0, 16'h0010, 9'h003, 16'h0000, 1'b1, 16'h0016);
        quick_branch("b_wrap", 3'b111, 1'b0, 16'h0000, 9'h1FF, 16'h0000, 1'b1, 16'hFFFE);
        quick_branch("br_un", 3'b111, 1'b1, 16'h2000, 9'h055, 16'hBEEF, 1'b1, 16'hBEEF);
        V_flag = 1'b0;
        quick_branch("br_ov_nt", 3'b110, 1'b1, 16'h4000, 9'h000, 16'h1234, 1'b0, 16'h4000);

        // Two writers in flight; condition only holds once the second write lands.
        Z_flag = 1'b0;
        flag_set = 1'b1;
        next_cycle();
        next_cycle();
        flag_set = 1'b0;
        set_branch(3'b001, 1'b0, 16'h0100, 9'h010, 16'h0000);
        for (int k = 0; k <= 7; k++) begin
            br_valid  = (k == 0);
            flag_done = (k == 3 || k == 5);
            if (k == 6) Z_flag = 1'b1;
            @(negedge clk);
            if (k <= 6) begin
                check("wait2_stall", 32'(stall), 1);
                check("wait2_resolved", 32'(resolved), 0);
            end else begin
                check("wait2_resolved", 32'(resolved), 1);
                check("wait2_taken", 32'(taken), 1);
                check("wait2_target", 32'(target), 32'h0120);
            end
            next_cycle();
        end

        // Simultaneous set/done with one writer pending: counter holds, branch keeps waiting.
        flag_set = 1'b1;
        next_cycle();
        set_branch(3'b111, 1'b0, 16'h0300, 9'h000, 16'h0000);
        for (int k = 0; k <= 5; k++) begin
            br_valid  = (k == 0);
            flag_set  = (k == 1);
            flag_done = (k == 1 || k == 3);
            @(negedge clk);
            if (k <= 4) begin
                check("both_stall", 32'(stall), 1);
                check("both_resolved", 32'(resolved), 0);
            end else begin
                check("both_resolved", 32'(resolved), 1);
                check("both_target", 32'(target), 32'h0300);
            end
            next_cycle();
        end

        // Reset while a branch sits in WAIT, then a normal branch afterwards.
        flag_set = 1'b1;
        next_cycle();
        flag_set = 1'b0;
        set_branch(3'b111, 1'b0, 16'h0500, 9'h000, 16'h0000);
        br_valid = 1'b1;
        next_cycle();
        br_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("wait_before_rst", 32'(stall), 1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        quick_branch("after_rst", 3'b111, 1'b0, 16'h0040, 9'h004, 16'h0000, 1'b1, 16'h0048);

        for (int i = 0; i < 600; i++) begin
            br_valid  = ($urandom_range(0, 2) == 0);
            flag_set  = ($urandom_range(0, 5) == 0);
            flag_done = ($urandom_range(0, 4) == 0);
            {N_flag, Z_flag, V_flag} = 3'($urandom);
            set_branch(3'($urandom), 1'($urandom), 16'($urandom), 9'($urandom), 16'($urandom));
            next_cycle();
        end

        br_valid = 1'b0;
        flag_set = 1'b0;
        flag_done = 1'b1;
        repeat (5) next_cycle();
        flag_done = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
`ifdef BRANCH_STATS_EN
        check("total_cnt", 32'(br_total_cnt), tot_m);
        check("taken_cnt", 32'(br_taken_cnt), tak_m);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port br_valid, input, 1 bit: a branch instruction is presented this cycle.
REQ-004 SHALL have port br_cond, input, 3 bits: condition code.
REQ-005 SHALL have port br_reg, input, 1 bit: 1 = BR (register target), 0 = B (PC-relative).
REQ-006 SHALL have port pc_plus2, input, 16 bits: address of the branch plus 2.
REQ-007 SHALL have port imm9, input, 9 bits: signed word offset.
REQ-008 SHALL have port rs_data, input, 16 bits: register target for BR.
REQ-009 SHALL have port flag_set, input, 1 bit: a flag-writing instruction entered the pipeline.
REQ-010 SHALL have port flag_done, input, 1 bit: the flag register is written this cycle.
REQ-011 SHALL have ports N_flag, Z_flag, V_flag, input, 1 bit each: registered flag values.
REQ-012 SHALL have port stall, output, 1 bit: fetch must hold.
REQ-013 SHALL have port resolved, output, 1 bit: one-cycle pulse; taken and target are valid.
REQ-014 SHALL have port taken, output, 1 bit: branch condition met.
REQ-015 SHALL have port target, output, 16 bits: next PC when taken.

Function
REQ-016 SHALL keep a 2-bit pending-flag counter: +1 on flag_set only, -1 on flag_done only, unchanged when both or neither are asserted, saturating at 3 and at 0.
REQ-017 SHALL implement FSM states IDLE, WAIT and EVAL.
REQ-018 In IDLE with br_valid=1, SHALL capture br_cond, br_reg, pc_plus2, imm9 and rs_data internally; the next state is EVAL if the counter is 0 and neither flag_set nor flag_done is asserted, else WAIT.
REQ-019 In WAIT, SHALL ignore br_valid and move to EVAL in the cycle after the counter reads 0.
REQ-020 In EVAL, SHALL sample N/Z/V, register taken and target, pulse resolved for one cycle, and return to IDLE.
REQ-021 SHALL assert stall combinationally in IDLE when br_valid=1, and in WAIT and EVAL; stall SHALL be 0 otherwise.
REQ-022 Latency with no pending flags SHALL be 2 cycles from br_valid to resolved.
REQ-023 Conditions SHALL be decoded as follows:
- 000 NE: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 and N=0
- 011 LT: N=1
- 100 GE: Z=1 or (Z=0 and N=0)
- 101 LE: N=1 or Z=1
- 110 OV: V=1
- 111 UN: always
REQ-024 For B, target SHALL be pc_plus2 + (sign-extend(imm9) << 1), modulo 2^16 (wrap-around ignored).
REQ-025 For BR, target SHALL be rs_data unmodified; when not taken, target SHALL equal pc_plus2.
REQ-026 flag_set and flag_done SHALL continue to update the counter in every state.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-WAIT, force: state IDLE, counter 0, stall 0, resolved 0, taken 0, target 16'h0000, captured fields 0.

Configuration
REQ-028 With BRANCH_STATS_EN defined, SHALL add outputs br_taken_cnt and br_total_cnt (16 bits each, saturating at 16'hFFFF, cleared by reset), incremented on each resolved pulse; br_taken_cnt increments only when taken=1.
REQ-029 Without BRANCH_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The condition-code enum (NE..UN) and FSM state enum SHALL reside in the shared package cpu_pkg.
REQ-031 Condition evaluation SHALL be the combinational sub-module br_cond_eval (inputs: cond, N, Z, V; output: met).

Verification
REQ-032 Bench SHALL cover: counter 0, B cond=001, Z=1, pc_plus2=16'h0010, imm9=9'h003 -> resolved 2 cycles later, taken=1, target=16'h0016.
REQ-033 Bench SHALL cover: imm9=9'h1FF, pc_plus2=16'h0000 -> target=16'hFFFE (wrap-around).
REQ-034 Bench SHALL cover: flag_set twice, then br_valid, flag_done at cycles +3 and +5 -> stall held throughout, resolved in cycle +7, flags sampled after the second write.
REQ-035 Bench SHALL cover: flag_set and flag_done in the same cycle with counter 1 -> counter stays 1, branch remains in WAIT.
REQ-036 Bench SHALL cover: BR cond=111, rs_data=16'hBEEF -> taken=1, target=16'hBEEF; cond=110 with V=0 -> taken=0, target=pc_plus2.
REQ-037 Bench SHALL cover: rst_n pulsed low during WAIT -> all outputs 0, and the next branch resolves normally; with BRANCH_STATS_EN, counters read 0 after reset.
